// File: rtl/rr_mux_arbiter_pkg.sv
// Shared helpers for the round-robin mux arbiter.
//   next_ptr(g, n) : priority pointer value after granting requester g
//                    out of n requesters (wraps n-1 -> 0, works for any n).
package rr_mux_arbiter_pkg;

  function automatic int unsigned next_ptr(input int unsigned g, input int unsigned n);
    return (g == n - 32'd1) ? 32'd0 : g + 32'd1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick (purely combinational).
// Scans req starting at ptr, wrapping modulo N. It returns the first set
// position as an absolute index. N need not be a power of two.
// Ports:
//   req   [N-1:0]  : request vector
//   ptr   [IW-1:0] : highest-priority position, always < N
//   grant [IW-1:0] : index of the winning requester (0 when any == 0)
//   any            : at least one request is set
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);

  // Walk the offsets from farthest to nearest. The nearest requester to
  // ptr is written last and wins. This gives the rotate, priority-encode
  // and un-rotate steps in one loop. Indices are wrapped by a subtract,
  // so no power-of-two modulo is assumed.
  always_comb begin
    grant = '0;
    for (int off = N - 1; off >= 0; off--) begin
      int idx;
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (req[idx]) grant = IW'(idx);
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered N:1 mux output among N
// valid/ready producers. When the one-entry output register is free, or is
// being drained this cycle, it accepts one requester per cycle.
// Ports:
//   clk              : clock, all state on posedge
//   rst_n            : synchronous active-low reset
//   req_vld  [N-1:0] : per-requester valid
//   req_data [N*W-1:0]: requester k data at [k*W +: W]
//   req_rdy  [N-1:0] : per-requester ready, one-hot or zero
//   out_vld          : output register holds a word
//   out_data [W-1:0] : registered word
//   out_src  [IW-1:0]: requester that supplied out_data
//   out_rdy          : consumer accepts when out_vld && out_rdy
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_vld,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_rdy,
  output logic           out_vld,
  output logic [W-1:0]   out_data,
  output logic [IW-1:0]  out_src,
  input  logic           out_rdy
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] grant;
  logic          any_req;
  logic          slot_free;
  logic          fire;
  logic [W-1:0]  sel_data;

  rr_priority_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req_vld),
    .ptr   (ptr),
    .grant (grant),
    .any   (any_req)
  );

  // The slot counts as free while it is being drained. This lets a fill
  // land on the same edge as the drain, with no bubble.
  assign slot_free = !out_vld || out_rdy;
  assign fire      = rst_n && slot_free && any_req;

  always_comb begin
    req_rdy = '0;
    if (fire) req_rdy[grant] = 1'b1;
  end

  always_comb sel_data = req_data[int'(grant) * W +: W];

  // Output register stage: capture the granted word, or retire the drained one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (fire) begin
      out_vld  <= 1'b1;
      out_data <= sel_data;
      out_src  <= grant;
      ptr      <= IW'(next_ptr(32'(grant), 32'(N)));
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter (N=4, W=8).
// It has two parts. The first is a table of directed vectors with
// hand-derived expected values, covering reset, rotation, wrap,
// backpressure, drain and mid-operation reset. The second is randomized
// traffic. Both are compared every cycle against a behavioural model that
// applies the round-robin rules directly.
module tb_rr_mux_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = $clog2(N);

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_vld;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_rdy;
  logic           out_vld;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_src;
  logic           out_rdy;

  rr_mux_arbiter #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_src  (out_src),
    .out_rdy  (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  logic         m_vld  = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_src  = 0;
  int           m_ptr  = 0;

  // Return the first requesting index, scanning from m_ptr with wrap.
  // Return -1 when no requester is valid.
  function automatic int model_pick(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  logic [N-1:0]  obs_rdy;
  logic          obs_vld;
  logic [W-1:0]  obs_data;
  logic [IW-1:0] obs_src;

  // Drive one cycle, check req_rdy before the edge and the outputs after it.
  task automatic run_cycle(input logic rn, input logic [N-1:0] v,
                           input logic [N*W-1:0] d, input logic ordy);
    int           g;
    logic         free;
    logic [N-1:0] exp_rdy;
    rst_n = rn; req_vld = v; req_data = d; out_rdy = ordy;
    #1;
    g       = model_pick(v);
    free    = !m_vld || ordy;
    exp_rdy = '0;
    if (rn && free && g >= 0) exp_rdy[g] = 1'b1;
    obs_rdy = req_rdy;
    chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    @(posedge clk);
    if (!rn) begin
      m_vld = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
    end else if (free && g >= 0) begin
      m_vld  = 1'b1;
      m_data = d[g*W +: W];
      m_src  = g;
      m_ptr  = (g + 1) % N;
    end else if (free) begin
      m_vld = 1'b0;
    end
    #1;
    obs_vld = out_vld; obs_data = out_data; obs_src = out_src;
    chk("out_vld", 32'(out_vld), 32'(m_vld));
    if (m_vld || !rn) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_src", 32'(out_src), 32'(m_src));
    end
  endtask

  typedef struct {
    logic           rn;
    logic [N-1:0]   vld;
    logic [N*W-1:0] data;
    logic           ordy;
    logic [N-1:0]   e_rdy;
    logic           e_vld;
    logic [W-1:0]   e_data;
    logic [IW-1:0]  e_src;
  } vec_t;

  localparam logic [N*W-1:0] DA = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  localparam logic [N*W-1:0] D5 = {8'hA3, 8'hA2, 8'h55, 8'hA0};
  localparam logic [N*W-1:0] D7 = {8'hA3, 8'h77, 8'hA1, 8'hA0};

  vec_t tbl[26];

  function automatic vec_t mk(input logic rn, input logic [N-1:0] v, input logic [N*W-1:0] d,
                              input logic ordy, input logic [N-1:0] er, input logic ev,
                              input logic [W-1:0] ed, input logic [IW-1:0] es);
    vec_t r;
    r.rn = rn; r.vld = v; r.data = d; r.ordy = ordy;
    r.e_rdy = er; r.e_vld = ev; r.e_data = ed; r.e_src = es;
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; req_vld = '0; req_data = '0; out_rdy = 1'b0;

    // reset hold with everyone requesting
    tbl[0]  = mk(0, 4'b1111, DA, 1, 4'b0000, 0, 8'h00, 0);
    tbl[1]  = mk(0, 4'b1111, DA, 1, 4'b0000, 0, 8'h00, 0);
    tbl[2]  = mk(0, 4'b1111, DA, 1, 4'b0000, 0, 8'h00, 0);
    // full rotation 0,1,2,3,0,1
    tbl[3]  = mk(1, 4'b1111, DA, 1, 4'b0001, 1, 8'hA0, 0);
    tbl[4]  = mk(1, 4'b1111, DA, 1, 4'b0010, 1, 8'hA1, 1);
    tbl[5]  = mk(1, 4'b1111, DA, 1, 4'b0100, 1, 8'hA2, 2);
    tbl[6]  = mk(1, 4'b1111, DA, 1, 4'b1000, 1, 8'hA3, 3);
    tbl[7]  = mk(1, 4'b1111, DA, 1, 4'b0001, 1, 8'hA0, 0);
    tbl[8]  = mk(1, 4'b1111, DA, 1, 4'b0010, 1, 8'hA1, 1);
    // sparse / wrap: grant 2, then 0011 -> 0 then 1, then 1000 -> 3
    tbl[9]  = mk(1, 4'b0100, DA, 1, 4'b0100, 1, 8'hA2, 2);
    tbl[10] = mk(1, 4'b0011, DA, 1, 4'b0001, 1, 8'hA0, 0);
    tbl[11] = mk(1, 4'b0011, DA, 1, 4'b0010, 1, 8'hA1, 1);
    tbl[12] = mk(1, 4'b1000, DA, 1, 4'b1000, 1, 8'hA3, 3);
    // backpressure on 0x55 from requester 1
    tbl[13] = mk(1, 4'b0010, D5, 1, 4'b0010, 1, 8'h55, 1);
    tbl[14] = mk(1, 4'b1111, D5, 0, 4'b0000, 1, 8'h55, 1);
    tbl[15] = mk(1, 4'b1111, D5, 0, 4'b0000, 1, 8'h55, 1);
    tbl[16] = mk(1, 4'b1111, D5, 0, 4'b0000, 1, 8'h55, 1);
    tbl[17] = mk(1, 4'b1111, D5, 0, 4'b0000, 1, 8'h55, 1);
    tbl[18] = mk(1, 4'b1111, D5, 1, 4'b0100, 1, 8'hA2, 2);
    // drain with no requests, pointer stays at 3
    tbl[19] = mk(1, 4'b0000, DA, 1, 4'b0000, 0, 8'hA2, 2);
    tbl[20] = mk(1, 4'b0000, DA, 1, 4'b0000, 0, 8'hA2, 2);
    tbl[21] = mk(1, 4'b1001, DA, 1, 4'b1000, 1, 8'hA3, 3);
    // reset mid-operation discards held 0x77, order restarts at 0
    tbl[22] = mk(1, 4'b0100, D7, 1, 4'b0100, 1, 8'h77, 2);
    tbl[23] = mk(1, 4'b1111, D7, 0, 4'b0000, 1, 8'h77, 2);
    tbl[24] = mk(0, 4'b1111, D7, 0, 4'b0000, 0, 8'h00, 0);
    tbl[25] = mk(1, 4'b1111, DA, 1, 4'b0001, 1, 8'hA0, 0);

    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
      run_cycle(tbl[i].rn, tbl[i].vld, tbl[i].data, tbl[i].ordy);
      chk($sformatf("vec%0d_rdy", i), 32'(obs_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_vld", i), 32'(obs_vld), 32'(tbl[i].e_vld));
      chk($sformatf("vec%0d_data", i), 32'(obs_data), 32'(tbl[i].e_data));
      chk($sformatf("vec%0d_src", i), 32'(obs_src), 32'(tbl[i].e_src));
    end

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic           rn;
      logic [N-1:0]   v;
      logic [N*W-1:0] d;
      logic           ordy;
      rn   = ($urandom_range(0, 59) != 0);
      v    = N'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
      run_cycle(rn, v, d, ordy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
